// File: rtl/multi_cycle_mul_unit_if.sv
// multi_cycle_mul_unit_if: issue-side and result-bus signals of the iterative multiply unit
interface multi_cycle_mul_unit_if #(
  parameter int ROBsize = 16,
  parameter int ROBsizeLog = $clog2(ROBsize + 1)
);
  logic rs_ready;
  logic [63:0] rs_val1;
  logic [63:0] rs_val2;
  logic [9:0] rs_commands;
  logic [ROBsizeLog-1:0] rs_tag;
  logic stall;
  logic flush;
  logic result_ack;
  logic result_valid;
  logic [ROBsizeLog-1:0] result_tag;
  logic [64:0] result_val;
  modport slave (
    input rs_ready, rs_val1, rs_val2, rs_commands, rs_tag, flush, result_ack,
    output stall, result_valid, result_tag, result_val
  );
  modport master (
    output rs_ready, rs_val1, rs_val2, rs_commands, rs_tag, flush, result_ack,
    input stall, result_valid, result_tag, result_val
  );
endinterface

// File: rtl/multi_cycle_mul_unit.sv
// multi_cycle_mul_unit: 64-cycle radix-2 shift-add multiplier presenting a tagged result to the result bus
module multi_cycle_mul_unit #(
  parameter int ROBsize = 16,
  parameter int ROBsizeLog = $clog2(ROBsize + 1)
) (
  input logic clk_i,
  input logic reset_i,
  multi_cycle_mul_unit_if.slave bus
);
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  state_t state, state_nxt;
  logic [5:0] cnt;
  logic [127:0] acc, acc_nxt, prod;
  logic [63:0] mcand, res;
  logic [64:0] sum;
  logic [ROBsizeLog-1:0] tag;
  logic [1:0] op;
  logic neg, a_sgn, b_sgn, unused_cmd;
  assign unused_cmd = ^bus.rs_commands[9:2];
  // acc holds {partial high, remaining multiplier bits}; one bit is retired per cycle
  always_comb begin
    a_sgn = bus.rs_commands[1:0] == 2'b01 || bus.rs_commands[1:0] == 2'b10;
    b_sgn = bus.rs_commands[1:0] == 2'b01;
    sum = {1'b0, acc[127:64]} + (acc[0] ? {1'b0, mcand} : 65'd0);
    acc_nxt = {sum, acc[63:1]};
    prod = neg ? -acc_nxt : acc_nxt;
    state_nxt = bus.flush ? IDLE :
                state == IDLE ? (bus.rs_ready ? BUSY : IDLE) :
                state == BUSY ? (cnt == 6'd63 ? DONE : BUSY) :
                (bus.result_ack ? IDLE : DONE);
  end
  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      state <= IDLE;
      cnt <= '0;
      acc <= '0;
      mcand <= '0;
      res <= '0;
      tag <= '0;
      op <= '0;
      neg <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && state_nxt == BUSY) begin
        mcand <= a_sgn && bus.rs_val1[63] ? -bus.rs_val1 : bus.rs_val1;
        acc <= {64'd0, b_sgn && bus.rs_val2[63] ? -bus.rs_val2 : bus.rs_val2};
        neg <= (a_sgn & bus.rs_val1[63]) ^ (b_sgn & bus.rs_val2[63]);
        tag <= bus.rs_tag;
        op <= bus.rs_commands[1:0];
        cnt <= '0;
      end
      if (state == BUSY) begin
        cnt <= cnt + 6'd1;
        acc <= acc_nxt;
        if (cnt == 6'd63) res <= op == 2'b00 ? prod[63:0] : prod[127:64];
      end
    end
  end
  assign bus.stall = state != IDLE;
  assign bus.result_valid = state == DONE;
  assign bus.result_tag = state == DONE ? tag : '0;
  assign bus.result_val = state == DONE ? {1'b1, res} : 65'd0;
endmodule
